wb_regfile: RTL and testbench

// - Write-back stage plus integer register file for the pipelined RV32I core.
// - Consumes the W-stage control from the M/W control register (RegWriteW, ResultSrcW) and the W-stage datapath values.
// - Selects ResultW, commits it to the register file, and serves the two decode-stage read ports.
// - Holds a sequential clear engine and a retired-write counter.

---
 rtl/wb_regfile.sv | 173 +++++++++++++++++
 tb/tb_wb_regfile.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_regfile.sv
// ----------------------------------------------------------------------------
// wb_regfile
//   Write-back stage and integer register file for the pipelined RV32I core.
//   The W-stage result is selected from the ALU result, the load data or the
//   PC+4 link value. It is committed to the register file, which serves the
//   two decode-stage read ports combinationally. After every reset a
//   sequential clear engine zeroes one register per cycle. Writes are accepted
//   only once the engine has finished. A counter tracks retired writes.
//
// Configuration macro:
//   WB_BYPASS_EN  defined   -> a read of the register being written this cycle
//                              returns ResultW (write-through).
//                 undefined -> such a read returns the old register value until
//                              the posedge commits the write.
//
// Ports:
//   clk         in   1       clock, all state changes on posedge
//   reset       in   1       synchronous, active-high reset
//   RegWriteW   in   1       register write enable (W stage)
//   ResultSrcW  in   2       result select: 00 ALU, 01 load, 10 PC+4, 11 zero
//   ALUResultW  in   XLEN    ALU result (W stage)
//   ReadDataW   in   XLEN    load data (W stage)
//   PCPlus4W    in   XLEN    PC+4 link value (W stage)
//   RdW         in   REG_AW  destination register (W stage)
//   Rs1D        in   REG_AW  read address 1 (D stage)
//   Rs2D        in   REG_AW  read address 2 (D stage)
//   RD1D        out  XLEN    read data 1 (combinational)
//   RD2D        out  XLEN    read data 2 (combinational)
//   ResultW     out  XLEN    selected W result (combinational)
//   rf_ready    out  1       clear sequence done, writes accepted
//   wb_count    out  32      number of committed writes (wraps)
// ----------------------------------------------------------------------------
module wb_regfile #(
   parameter int XLEN   = 32,
   parameter int REG_AW = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              RegWriteW,
   input  logic [1:0]        ResultSrcW,
   input  logic [XLEN-1:0]   ALUResultW,
   input  logic [XLEN-1:0]   ReadDataW,
   input  logic [XLEN-1:0]   PCPlus4W,
   input  logic [REG_AW-1:0] RdW,
   input  logic [REG_AW-1:0] Rs1D,
   input  logic [REG_AW-1:0] Rs2D,
   output logic [XLEN-1:0]   RD1D,
   output logic [XLEN-1:0]   RD2D,
   output logic [XLEN-1:0]   ResultW,
   output logic              rf_ready,
   output logic [31:0]       wb_count
);

   localparam int NREGS = 2 ** REG_AW;
   localparam logic [REG_AW-1:0] LAST_IDX = REG_AW'(NREGS - 1);

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [REG_AW-1:0] r_clr_idx;
   logic [REG_AW-1:0] w_clr_idx_nxt;
   logic [XLEN-1:0]   r_regs [NREGS];
   logic [31:0]       r_wb_count;
   logic              w_run;
   logic              w_commit;

   // -------------------------------------------------------------------------
   // Result mux
   // -------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal driven from always_comb gets a default first, so no
      // path through the block can leave it unassigned and infer a latch.
      ResultW = '0;
      unique case (ResultSrcW)
         2'b00:   ResultW = ALUResultW;
         2'b01:   ResultW = ReadDataW;
         2'b10:   ResultW = PCPlus4W;
         default: ResultW = '0;
      endcase
   end

   assign w_run    = (r_state == ST_RUN);
   // x0 is hard-wired to zero, so a write to it is counted but never stored.
   assign w_commit = w_run && RegWriteW && (RdW != '0);

   // -------------------------------------------------------------------------
   // Clear / run state machine
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      if (reset) begin
         r_state   <= ST_CLEAR;
         r_clr_idx <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_clr_idx <= w_clr_idx_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_clr_idx_nxt = r_clr_idx;
      unique case (r_state)
         ST_CLEAR: begin
            w_clr_idx_nxt = r_clr_idx + REG_AW'(1);
            if (r_clr_idx == LAST_IDX) begin
               w_state_nxt = ST_RUN;
            end
         end
         default: begin
            w_state_nxt = ST_RUN;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Register array
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      // NOTE: the array has no reset branch. It maps to plain storage with
      // no reset network. The clear engine zeroes it one entry per cycle, and
      // reads are masked to zero until that finishes.
      if (!reset) begin
         if (r_state == ST_CLEAR) begin
            r_regs[r_clr_idx] <= '0;
         end else if (w_commit) begin
            r_regs[RdW] <= ResultW;
         end
      end
   end

   // -------------------------------------------------------------------------
   // Retired-write counter: every RUN-state write request counts, x0 included.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wb_count <= '0;
      end else if (w_run && RegWriteW) begin
         r_wb_count <= r_wb_count + 32'd1;
      end
   end

   // -------------------------------------------------------------------------
   // Read ports
   // -------------------------------------------------------------------------
   always_comb begin
      RD1D = '0;
      RD2D = '0;
      if (w_run) begin
`ifdef WB_BYPASS_EN
         // Write-through: the value being committed this cycle is forwarded.
         if (Rs1D == '0)                    RD1D = '0;
         else if (w_commit && Rs1D == RdW)  RD1D = ResultW;
         else                               RD1D = r_regs[Rs1D];
         if (Rs2D == '0)                    RD2D = '0;
         else if (w_commit && Rs2D == RdW)  RD2D = ResultW;
         else                               RD2D = r_regs[Rs2D];
`else
         if (Rs1D != '0) RD1D = r_regs[Rs1D];
         if (Rs2D != '0) RD2D = r_regs[Rs2D];
`endif
      end
   end

   assign rf_ready = w_run;
   assign wb_count = r_wb_count;

endmodule

// File: tb/tb_wb_regfile.sv
// ----------------------------------------------------------------------------
// tb_wb_regfile
//   Self-checking bench for wb_regfile. A behavioural model holds the
//   architectural register contents, the number of clear cycles still to go
//   and the retired-write count. Every cycle, all outputs are compared with
//   the model before the clock edge. The model is then advanced by the inputs
//   that the edge samples. The expectation for a read of the register being
//   written follows WB_BYPASS_EN.
// ----------------------------------------------------------------------------
module tb_wb_regfile;

   localparam int NREGS = 32;

   logic        clk;
   logic        reset;
   logic        RegWriteW;
   logic [1:0]  ResultSrcW;
   logic [31:0] ALUResultW;
   logic [31:0] ReadDataW;
   logic [31:0] PCPlus4W;
   logic [4:0]  RdW;
   logic [4:0]  Rs1D;
   logic [4:0]  Rs2D;
   logic [31:0] RD1D;
   logic [31:0] RD2D;
   logic [31:0] ResultW;
   logic        rf_ready;
   logic [31:0] wb_count;

   wb_regfile #(.XLEN(32), .REG_AW(5)) dut (
      .clk        (clk),
      .reset      (reset),
      .RegWriteW  (RegWriteW),
      .ResultSrcW (ResultSrcW),
      .ALUResultW (ALUResultW),
      .ReadDataW  (ReadDataW),
      .PCPlus4W   (PCPlus4W),
      .RdW        (RdW),
      .Rs1D       (Rs1D),
      .Rs2D       (Rs2D),
      .RD1D       (RD1D),
      .RD2D       (RD2D),
      .ResultW    (ResultW),
      .rf_ready   (rf_ready),
      .wb_count   (wb_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model state
   logic [31:0] m_regs [NREGS];
   int          m_clear_left;
   logic [31:0] m_count;
   bit          m_known;

   int n_checks;
   int n_errors;
   int n_cycle;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s (cycle %0d): got %h expected %h", tag, n_cycle, got, exp);
      end
   endtask

   function automatic logic [31:0] exp_result();
      case (ResultSrcW)
         2'd0:    return ALUResultW;
         2'd1:    return ReadDataW;
         2'd2:    return PCPlus4W;
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic [31:0] exp_read(input logic [4:0] rs);
      if (m_clear_left != 0) return 32'd0;
      if (rs == 5'd0)        return 32'd0;
`ifdef WB_BYPASS_EN
      if (RegWriteW && RdW != 5'd0 && rs == RdW) return exp_result();
`endif
      return m_regs[rs];
   endfunction

   // One clock cycle: drive inputs, compare outputs before the edge, then
   // advance the model with what the edge samples.
   task automatic cycle(input logic rst, input logic we, input logic [1:0] src,
                        input logic [31:0] alu, input logic [31:0] ld,
                        input logic [31:0] pc4, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2);
      reset      = rst;
      RegWriteW  = we;
      ResultSrcW = src;
      ALUResultW = alu;
      ReadDataW  = ld;
      PCPlus4W   = pc4;
      RdW        = rd;
      Rs1D       = rs1;
      Rs2D       = rs2;
      #1;
      check("result", ResultW, exp_result());
      if (m_known) begin
         check("rd1", RD1D, exp_read(rs1));
         check("rd2", RD2D, exp_read(rs2));
         check("ready", {31'd0, rf_ready}, {31'd0, m_clear_left == 0});
         check("count", wb_count, m_count);
      end
      @(posedge clk);
      if (rst) begin
         m_known      = 1'b1;
         m_clear_left = NREGS;
         m_count      = 32'd0;
         for (int i = 0; i < NREGS; i++) m_regs[i] = 32'd0;
      end else if (m_clear_left != 0) begin
         m_clear_left--;
      end else if (we) begin
         m_count++;
         if (rd != 5'd0) m_regs[rd] = exp_result();
      end
      n_cycle++;
      #1;
   endtask

   task automatic idle_read(input logic [4:0] rs1, input logic [4:0] rs2);
      cycle(1'b0, 1'b0, 2'b00, $urandom, $urandom, $urandom, 5'($urandom), rs1, rs2);
   endtask

   task automatic write_alu(input logic [4:0] rd, input logic [31:0] val,
                            input logic [4:0] rs1, input logic [4:0] rs2);
      cycle(1'b0, 1'b1, 2'b00, val, $urandom, $urandom, rd, rs1, rs2);
   endtask

   // Clear phase with random write attempts, which must be ignored.
   task automatic clear_phase();
      for (int i = 0; i < NREGS; i++) begin
         cycle(1'b0, 1'b1, 2'($urandom), $urandom, $urandom, $urandom,
               5'($urandom_range(1, 31)), 5'($urandom), 5'($urandom));
      end
   endtask

   task automatic read_all();
      for (int i = 0; i < NREGS; i++) idle_read(5'(i), 5'(NREGS - 1 - i));
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      n_cycle  = 0;
      m_known  = 1'b0;
      m_clear_left = NREGS;
      m_count  = 32'd0;
      for (int i = 0; i < NREGS; i++) m_regs[i] = 32'd0;

      // Reset held for three cycles, then the clear sequence.
      repeat (3) cycle(1'b1, 1'b1, 2'b00, $urandom, 0, 0, 5'd3, 5'd3, 5'd4);
      clear_phase();
      read_all();

      // Basic write and read-back.
      write_alu(5'd5, 32'hDEADBEEF, 5'd0, 5'd0);
      idle_read(5'd5, 5'd0);

      // Result mux: load data, link value, and the zero select.
      cycle(1'b0, 1'b1, 2'b01, $urandom, 32'h11, $urandom, 5'd6, 5'd0, 5'd0);
      cycle(1'b0, 1'b1, 2'b10, $urandom, $urandom, 32'h104, 5'd7, 5'd0, 5'd0);
      cycle(1'b0, 1'b1, 2'b11, $urandom, $urandom, $urandom, 5'd8, 5'd6, 5'd7);
      idle_read(5'd6, 5'd7);
      idle_read(5'd8, 5'd5);

      // x0 is never written but the request is counted.
      write_alu(5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
      idle_read(5'd0, 5'd0);

      // Read-during-write on x9.
      write_alu(5'd9, 32'd1, 5'd0, 5'd0);
      write_alu(5'd9, 32'hA5A5A5A5, 5'd9, 5'd9);
      idle_read(5'd9, 5'd9);

      // Reset mid-run: counter cleared, writes during clear ignored.
      write_alu(5'd10, 32'h12345678, 5'd0, 5'd0);
      cycle(1'b1, 1'b1, 2'b00, 32'hCAFEF00D, 0, 0, 5'd11, 5'd10, 5'd5);
      clear_phase();
      read_all();

      // Randomised traffic, with reads biased towards the write target and
      // an occasional reset.
      for (int i = 0; i < 600; i++) begin
         logic [4:0] rd;
         logic [4:0] rs1;
         logic [4:0] rs2;
         logic       rst;
         rd  = 5'($urandom);
         rs1 = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom);
         rs2 = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom);
         rst = ($urandom_range(0, 199) == 0);
         cycle(rst, 1'($urandom), 2'($urandom), $urandom, $urandom, $urandom,
               rd, rs1, rs2);
      end
      read_all();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
